// File: rtl/tetris_row_clear_if.sv
// Handshake and board-RAM bus between the game FSM, the row-clear sequencer and the board RAM.
// The score signal exists only when TETRIS_SCORE_EN is defined.
interface tetris_row_clear_if #(
  parameter int unsigned COLS   = 10,
  parameter int unsigned CELL_W = 3,
  parameter int unsigned ROW_AW = 5
);
  logic                     start;
  logic                     busy;
  logic                     done;
  logic [ROW_AW-1:0]        lines_cleared;
  logic [ROW_AW-1:0]        ram_addr;
  logic                     ram_rd;
  logic [COLS*CELL_W-1:0]   ram_rdata;
  logic                     ram_we;
  logic [COLS*CELL_W-1:0]   ram_wdata;
`ifdef TETRIS_SCORE_EN
  logic [19:0]              score;
`endif

  modport master (
    input  start, ram_rdata,
    output busy, done, lines_cleared, ram_addr, ram_rd, ram_we, ram_wdata
`ifdef TETRIS_SCORE_EN
    , output score
`endif
  );

  modport slave (
    output start, ram_rdata,
    input  busy, done, lines_cleared, ram_addr, ram_rd, ram_we, ram_wdata
`ifdef TETRIS_SCORE_EN
    , input score
`endif
  );
endinterface

// File: rtl/tetris_row_clear.sv
// Row-clear sequencer: scans the board RAM bottom to top, removes full rows by shifting rows above down.
// Optional score accumulator enabled by defining TETRIS_SCORE_EN.
module tetris_row_clear #(
  parameter int unsigned COLS   = 10,
  parameter int unsigned ROWS   = 20,
  parameter int unsigned CELL_W = 3,
  parameter int unsigned ROW_AW = 5
) (
  input  logic               clk,
  input  logic               reset,
  tetris_row_clear_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CHECK,
    S_SHIFT_RD,
    S_SHIFT_WR,
    S_CLEAR_TOP,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ROW_AW-1:0] r_q, r_d;
  logic [ROW_AW-1:0] s_q, s_d;
  logic [ROW_AW-1:0] lines_q, lines_d;
  logic              row_full;

  always_comb begin
    row_full = 1'b1;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (bus.ram_rdata[c*CELL_W +: CELL_W] == '0) row_full = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      s_q     <= '0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      s_q     <= s_d;
      lines_q <= lines_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    r_d           = r_q;
    s_d           = s_q;
    lines_d       = lines_q;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    bus.ram_rd    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    unique case (state_q)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          r_d     = ROW_AW'(ROWS - 1);
          lines_d = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        bus.ram_rd   = 1'b1;
        bus.ram_addr = r_q;
        state_d      = S_CHECK;
      end
      S_CHECK: begin
        if (row_full) begin
          s_d     = r_q;
          state_d = (r_q != '0) ? S_SHIFT_RD : S_CLEAR_TOP;
        end else if (r_q == '0) begin
          state_d = S_DONE;
        end else begin
          r_d     = r_q - 1'b1;
          state_d = S_READ;
        end
      end
      S_SHIFT_RD: begin
        bus.ram_rd   = 1'b1;
        bus.ram_addr = s_q - 1'b1;
        state_d      = S_SHIFT_WR;
      end
      S_SHIFT_WR: begin
        // Row s-1 read last cycle is on ram_rdata now; write it straight back one row lower.
        bus.ram_we    = 1'b1;
        bus.ram_addr  = s_q;
        bus.ram_wdata = bus.ram_rdata;
        s_d           = s_q - 1'b1;
        state_d       = (s_q == ROW_AW'(1)) ? S_CLEAR_TOP : S_SHIFT_RD;
      end
      S_CLEAR_TOP: begin
        bus.ram_we = 1'b1;
        lines_d    = lines_q + 1'b1;
        state_d    = S_READ;
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.lines_cleared = lines_q;

`ifdef TETRIS_SCORE_EN
  logic [19:0] score_q, score_d, bonus;
  logic [20:0] score_sum;

  always_comb begin
    unique case (lines_q[1:0])
      2'd0:    bonus = 20'd0;
      2'd1:    bonus = 20'd40;
      2'd2:    bonus = 20'd100;
      default: bonus = 20'd300;
    endcase
    if (lines_q >= ROW_AW'(4)) bonus = 20'd1200;
    score_sum = {1'b0, score_q} + {1'b0, bonus};
    score_d   = score_q;
    if (state_q == S_DONE) score_d = score_sum[20] ? '1 : score_sum[19:0];
  end

  always_ff @(posedge clk) begin
    if (reset) score_q <= '0;
    else       score_q <= score_d;
  end

  assign bus.score = score_q;
`endif

endmodule

// File: tb/tb_tetris_row_clear.sv
// Scoreboard bench for tetris_row_clear: behavioural board RAM, row-packing reference model,
// per-pass expectations queued at start and checked when done pulses.
module tb_tetris_row_clear;
  localparam int COLS   = 10;
  localparam int ROWS   = 20;
  localparam int CELL_W = 3;
  localparam int ROW_AW = 5;
  localparam int W      = COLS * CELL_W;

  typedef struct {
    int lines;
    int cycles;
    int writes;
    int score;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic load;
  int   checks = 0;
  int   errors = 0;
  int   score_exp = 0;
  exp_t exp_q[$];

  logic [W-1:0] mem        [ROWS];
  logic [W-1:0] load_board [ROWS];
  logic [W-1:0] exp_board  [ROWS];

  always #5 clk = ~clk;

  tetris_row_clear_if #(.COLS(COLS), .CELL_W(CELL_W), .ROW_AW(ROW_AW)) bus ();

  tetris_row_clear #(
    .COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W), .ROW_AW(ROW_AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Board RAM: one-cycle read latency, bulk preload from load_board.
  always @(posedge clk) begin
    if (load) mem <= load_board;
    else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_rd) bus.ram_rdata <= mem[bus.ram_addr];
  end

  function automatic bit is_full(input logic [W-1:0] row);
    for (int c = 0; c < COLS; c++)
      if (row[c*CELL_W +: CELL_W] == '0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] nonfull_row(input int i);
    logic [W-1:0] v = '0;
    for (int c = 0; c < COLS; c++)
      if (c != i % COLS) v[c*CELL_W +: CELL_W] = CELL_W'((i + c) % 7 + 1);
    return v;
  endfunction

  function automatic logic [W-1:0] full_row(input int i);
    logic [W-1:0] v = '0;
    for (int c = 0; c < COLS; c++) v[c*CELL_W +: CELL_W] = CELL_W'((i * 3 + c) % 7 + 1);
    return v;
  endfunction

  function automatic int bonus_of(input int lines);
    case (lines)
      0: return 0;
      1: return 40;
      2: return 100;
      3: return 300;
      default: return 1200;
    endcase
  endfunction

  // Loads load_board, runs one pass and checks it against the packed-board model.
  task automatic run_pass(input string name, input int extra_start_at);
    exp_t e;
    int   k, idx, n, writes;
    bit   overlap, seen;
    k = 0;
    e.cycles = 2 * ROWS + 1;
    e.writes = 0;
    // The k-th full row from the bottom has been pushed down k places when it is found.
    for (int o = ROWS - 1; o >= 0; o--) begin
      if (is_full(load_board[o])) begin
        e.cycles += 2 * (o + k) + 3;
        e.writes += o + k + 1;
        k++;
      end
    end
    e.lines = k;
    idx = ROWS - 1;
    for (int o = ROWS - 1; o >= 0; o--)
      if (!is_full(load_board[o])) begin exp_board[idx] = load_board[o]; idx--; end
    for (int o = idx; o >= 0; o--) exp_board[o] = '0;
    score_exp = score_exp + bonus_of(k);
    if (score_exp > 'hFFFFF) score_exp = 'hFFFFF;
    e.score = score_exp;
    exp_q.push_back(e);

    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0; bus.start = 1'b1;
    n = 0; writes = 0; overlap = 1'b0; seen = 1'b0;
    while (!seen && n < 4000) begin
      @(negedge clk);
      n++;
      bus.start = (n == extra_start_at);
      if (n == 1) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++; $display("FAIL %s busy_cycle1 got %b want 1", name, bus.busy);
        end
      end
      if (bus.ram_we === 1'b1) writes++;
      if (bus.ram_we === 1'b1 && bus.ram_rd === 1'b1) overlap = 1'b1;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    bus.start = 1'b0;

    e = exp_q.pop_front();
    checks++;
    if (!seen) begin errors++; $display("FAIL %s done_timeout got none want cycle %0d", name, e.cycles); end
    checks++;
    if (n != e.cycles) begin errors++; $display("FAIL %s done_cycle got %0d want %0d", name, n, e.cycles); end
    checks++;
    if (bus.lines_cleared !== ROW_AW'(e.lines)) begin
      errors++; $display("FAIL %s lines_cleared got %0d want %0d", name, bus.lines_cleared, e.lines);
    end
    checks++;
    if (writes != e.writes) begin errors++; $display("FAIL %s write_count got %0d want %0d", name, writes, e.writes); end
    checks++;
    if (overlap) begin errors++; $display("FAIL %s rd_we_overlap got 1 want 0", name); end

    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL %s after_done busy=%b done=%b want 0 0", name, bus.busy, bus.done);
    end
`ifdef TETRIS_SCORE_EN
    checks++;
    if (bus.score !== 20'(e.score)) begin
      errors++; $display("FAIL %s score got %0d want %0d", name, bus.score, e.score);
    end
`endif
    for (int r = 0; r < ROWS; r++) begin
      checks++;
      if (mem[r] !== exp_board[r]) begin
        errors++; $display("FAIL %s board_row%0d got %h want %h", name, r, mem[r], exp_board[r]);
      end
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    score_exp = 0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ram_rd !== 1'b0 || bus.ram_we !== 1'b0) begin
      errors++; $display("FAIL reset ctrl got busy=%b done=%b rd=%b we=%b want 0000",
                         bus.busy, bus.done, bus.ram_rd, bus.ram_we);
    end
    checks++;
    if (bus.ram_addr !== '0 || bus.ram_wdata !== '0 || bus.lines_cleared !== '0) begin
      errors++; $display("FAIL reset data got addr=%0d wdata=%h lines=%0d want 0 0 0",
                         bus.ram_addr, bus.ram_wdata, bus.lines_cleared);
    end
`ifdef TETRIS_SCORE_EN
    checks++;
    if (bus.score !== '0) begin errors++; $display("FAIL reset score got %0d want 0", bus.score); end
`endif
  endtask

  task automatic test_empty_board;
    for (int r = 0; r < ROWS; r++) load_board[r] = '0;
    run_pass("empty", 0);
  endtask

  task automatic test_bottom_row;
    for (int r = 0; r < ROWS; r++) load_board[r] = nonfull_row(r);
    load_board[ROWS-1] = full_row(0);
    load_board[ROWS-2] = {10{3'b101}} & ~(W'(7));
    run_pass("bottom_row", 0);
  endtask

  task automatic test_two_rows;
    for (int r = 0; r < ROWS; r++) load_board[r] = nonfull_row(r);
    load_board[ROWS-1] = full_row(1);
    load_board[ROWS-3] = full_row(2);
    run_pass("two_rows", 0);
  endtask

  task automatic test_top_row;
    for (int r = 0; r < ROWS; r++) load_board[r] = nonfull_row(r + 3);
    load_board[0] = full_row(4);
    run_pass("top_row", 0);
  endtask

  task automatic test_all_full;
    for (int r = 0; r < ROWS; r++) load_board[r] = full_row(r);
    run_pass("all_full", 0);
  endtask

  task automatic test_start_while_busy;
    for (int r = 0; r < ROWS; r++) load_board[r] = nonfull_row(r + 1);
    load_board[ROWS-1] = full_row(5);
    run_pass("start_busy", 45);
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < ROWS; r++) load_board[r] = nonfull_row(r);
    load_board[5]  = full_row(6);
    load_board[12] = full_row(7);
    run_pass("b2b_first", 0);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.lines_cleared !== ROW_AW'(2)) begin
      errors++; $display("FAIL b2b_hold lines_cleared got %0d want 2", bus.lines_cleared);
    end
    for (int r = 0; r < ROWS; r++) load_board[r] = nonfull_row(r + 7);
    run_pass("b2b_second", 0);
  endtask

  task automatic test_random;
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < ROWS; r++) begin
        logic [W-1:0] v;
        for (int c = 0; c < COLS; c++) v[c*CELL_W +: CELL_W] = CELL_W'($urandom_range(1, 7));
        if ($urandom_range(0, 3) != 0) v[$urandom_range(0, COLS-1)*CELL_W +: CELL_W] = '0;
        load_board[r] = v;
      end
      run_pass("random", 0);
    end
  endtask

  task automatic test_reset_mid_pass;
    int n;
    bit hit;
    for (int r = 0; r < ROWS; r++) load_board[r] = nonfull_row(r + 2);
    load_board[ROWS-1] = full_row(3);
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0; bus.start = 1'b1;
    n = 0; hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge clk);
      n++;
      bus.start = (n == 3);
      if (bus.ram_we === 1'b1 && bus.ram_addr !== '0) hit = 1'b1;
    end
    bus.start = 1'b0;
    checks++;
    if (!hit) begin errors++; $display("FAIL reset_mid shift_wr_seen got 0 want 1"); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    score_exp = 0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ram_we !== 1'b0) begin
      errors++; $display("FAIL reset_mid outputs got busy=%b done=%b we=%b want 000",
                         bus.busy, bus.done, bus.ram_we);
    end
  endtask

`ifdef TETRIS_SCORE_EN
  task automatic test_score;
    do_reset();
    for (int r = 0; r < ROWS; r++) load_board[r] = (r < 4) ? full_row(r) : nonfull_row(r);
    run_pass("score_4", 0);
    for (int r = 0; r < ROWS; r++) load_board[r] = (r == ROWS-1) ? full_row(r) : nonfull_row(r);
    run_pass("score_1", 0);
    for (int r = 0; r < ROWS; r++) load_board[r] = nonfull_row(r);
    run_pass("score_0", 0);
    while (score_exp < 'hFFFFF) begin
      for (int r = 0; r < ROWS; r++) load_board[r] = (r < 4) ? full_row(r) : '0;
      run_pass("score_sat", 0);
    end
  endtask
`endif

  initial begin
    reset     = 1'b1;
    load      = 1'b0;
    bus.start = 1'b0;
    for (int r = 0; r < ROWS; r++) load_board[r] = '0;
    test_reset();
    test_empty_board();
    test_bottom_row();
    test_two_rows();
    test_top_row();
    test_all_full();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    test_reset_mid_pass();
`ifdef TETRIS_SCORE_EN
    test_score();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
